seq_divider: RTL

- Iterative restoring divider that replaces the per-step combinational divide stage with a complete multi-cycle divide unit.
- Sits in the execute stage's multdiv path. The pipeline stalls on `busy` and captures results on `data_resultRDY`.
- Generalised in three ways:
  - parametrised width;
  - configurable number of restoring steps per clock;
  - signed or unsigned mode per operation.
- Adds a start handshake, a divide-by-zero exception and fixed, deterministic latency.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 41 ++++
 rtl/seq_divider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    // Divider FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in one dividend bit, trial-subtract, restore or keep.
// Latency: purely combinational, no registers.
// Backpressure: none; the enclosing FSM decides when the step result is captured.
//
// Ports:
//   rem_hi_i      partial remainder before the step (always < divisor_i)
//   rem_lo_msb_i  next dividend bit shifted into the remainder
//   divisor_i     divisor magnitude
//   rem_hi_o      partial remainder after the step
//   q_bit_o       quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_hi_i,
    input  logic             rem_lo_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_hi_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           cout;

    assign shifted = {rem_hi_i, rem_lo_msb_i};

    // WIDTH+1-bit subtraction as an adder with inverted divisor and carry-in 1.
    // Carry-out set means shifted >= divisor.
    assign {cout, trial} = {1'b0, shifted}
                         + {1'b0, ~{1'b0, divisor_i}}
                         + {{(WIDTH+1){1'b0}}, 1'b1};

    // Because the incoming remainder is below the divisor, a successful trial
    // always leaves trial[WIDTH] clear; folding it in keeps the whole
    // difference observed without changing the result.
    assign q_bit_o  = cout & ~trial[WIDTH];
    assign rem_hi_o = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider (signed/unsigned), STEPS_PER_CYCLE restoring steps per clock.
// Latency: start accepted at edge 0 -> data_resultRDY high in the cycle after edge N+1 (N = WIDTH/STEPS_PER_CYCLE).
// Backpressure: busy is high while a divide is in flight; ctrl_DIV is ignored then (not queued).
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   ctrl_DIV          start request, sampled only in IDLE
//   ctrl_signed       two's-complement mode, sampled with ctrl_DIV
//   data_operandA/B   dividend / divisor, sampled with ctrl_DIV
//   busy              state != IDLE
//   data_quotient     registered quotient, held until next completion
//   data_remainder    registered remainder (sign follows dividend), held until next completion
//   data_exception    divide-by-zero flag, held until next completion
//   data_resultRDY    one-cycle pulse, results valid this cycle
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1,
    parameter bit SIGNED_EN       = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int            N    = WIDTH / STEPS_PER_CYCLE;
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_hi_q;     // upper half of the 2*WIDTH remainder register
    logic [WIDTH-1:0] rem_lo_q;     // lower half: dividend bits out, quotient bits in
    logic [WIDTH-1:0] divisor_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div0_q;

    // Operand magnitudes; with SIGNED_EN=0 the negate paths are constant-folded away.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = SIGNED_EN && ctrl_signed && data_operandA[WIDTH-1];
    assign b_neg = SIGNED_EN && ctrl_signed && data_operandB[WIDTH-1];
    assign a_mag = a_neg ? -data_operandA : data_operandA;
    assign b_mag = b_neg ? -data_operandB : data_operandB;

    // Chain of STEPS_PER_CYCLE restoring steps evaluated in one clock.
    logic [WIDTH-1:0] hi_chain [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] lo_chain [0:STEPS_PER_CYCLE];

    assign hi_chain[0] = rem_hi_q;
    assign lo_chain[0] = rem_lo_q;

    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
        logic q_bit;

        div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .rem_hi_i     (hi_chain[k]),
            .rem_lo_msb_i (lo_chain[k][WIDTH-1]),
            .divisor_i    (divisor_q),
            .rem_hi_o     (hi_chain[k+1]),
            .q_bit_o      (q_bit)
        );

        assign lo_chain[k+1] = {lo_chain[k][WIDTH-2:0], q_bit};
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rem_hi_q       <= '0;
            rem_lo_q       <= '0;
            divisor_q      <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            div0_q         <= 1'b0;
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The accepting edge performs the operand load.
                    if (ctrl_DIV) begin
                        rem_hi_q  <= '0;
                        rem_lo_q  <= a_mag;
                        divisor_q <= b_mag;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= (data_operandB == '0);
                        cnt_q     <= '0;
                        state_q   <= LOAD;
                    end
                end
                // The LOAD cycle already runs the first iteration so that the
                // whole divide, including FIX, completes in N+1 edges.
                LOAD, CALC: begin
                    rem_hi_q <= hi_chain[STEPS_PER_CYCLE];
                    rem_lo_q <= lo_chain[STEPS_PER_CYCLE];
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= CALC;
                    end
                end
                FIX: begin
                    // Divide-by-zero still takes the full latency; results are forced to 0.
                    if (div0_q) begin
                        data_quotient  <= '0;
                        data_remainder <= '0;
                    end else begin
                        data_quotient  <= neg_quo_q ? -rem_lo_q : rem_lo_q;
                        data_remainder <= neg_rem_q ? -rem_hi_q : rem_hi_q;
                    end
                    data_exception <= div0_q;
                    data_resultRDY <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
